byte_striping_cond: RTL

- Transmit-side byte striper for the PHY. Takes one byte stream at the clk_2f rate and distributes it round-robin onto two lanes: even bytes go to lane 0, odd bytes to lane 1.
- Lanes carry half-rate data, realised by holding each lane word for two clk_2f cycles.
- Lane 1 is offset one cycle behind lane 0, so the lane pair feeds directly into the receive-side un-striper (lane_0/valid_0/lane_1/valid_1).

---
 rtl/byte_striping_cond_pkg.sv | 24 ++
 rtl/byte_striping_cond_stripe_lane_hold.sv | 58 +++++
 rtl/byte_striping_cond.sv | 119 +++++++++++
 3 files changed

// File: rtl/byte_striping_cond_pkg.sv
// Shared PHY definitions for the byte striper and its receive-side un-striper:
// one-hot state encodings, default lane width and idle value, counter helper.
package byte_striping_cond_pkg;

  localparam int unsigned BUS_WIDTH_DEF = 8;
  localparam logic [63:0] IDLE_DATA_DEF = 64'h0;
  localparam int unsigned CNT_W         = 16;

  // One-hot, 3-bit; the un-striper decodes the same values.
  typedef enum logic [2:0] {
    TRANSMITIENDO_LANE_1 = 3'b001,
    ESPERANDO_ENTRADA    = 3'b010,
    TRANSMITIENDO_LANE_0 = 3'b100
  } stripe_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    if (val == {CNT_W{1'b1}}) begin
      return val;
    end
    return val + 1'b1;
  endfunction

endpackage

// File: rtl/byte_striping_cond_stripe_lane_hold.sv
// One lane of the striper: word register, valid flag and a single age bit.
// A loaded word stays on the lane for two clk_2f cycles; if no reload arrives
// at the second edge the lane returns to the idle value with valid low.
module stripe_lane_hold
  import byte_striping_cond_pkg::*;
#(
  parameter int unsigned          BUS_WIDTH = BUS_WIDTH_DEF,
  parameter logic [BUS_WIDTH-1:0] IDLE_DATA = IDLE_DATA_DEF[BUS_WIDTH-1:0]
) (
  input  logic                 clk_2f,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic [BUS_WIDTH-1:0] data_i,
  output logic [BUS_WIDTH-1:0] lane_o,
  output logic                 valid_o
);

  logic [BUS_WIDTH-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 age_q, age_d;

  // Load wins; otherwise a valid word ages once, then expires to idle.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    age_d   = age_q;
    if (load_i) begin
      data_d  = data_i;
      valid_d = 1'b1;
      age_d   = 1'b0;
    end else if (valid_q) begin
      if (age_q) begin
        data_d  = IDLE_DATA;
        valid_d = 1'b0;
        age_d   = 1'b0;
      end else begin
        age_d   = 1'b1;
      end
    end
  end

  // Lane registers, cleared asynchronously to the idle word.
  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      data_q  <= IDLE_DATA;
      valid_q <= 1'b0;
      age_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      age_q   <= age_d;
    end
  end

  assign lane_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/byte_striping_cond.sv
// Transmit-side byte striper: even bytes of a burst go to lane 0, odd bytes
// to lane 1, each lane word held for two clk_2f cycles. Any gap in valid_in
// ends the burst and the next byte restarts on lane 0.
// Optional build macro BYTE_STRIPING_CNT_EN adds a saturating 16-bit count
// of accepted bytes on output byte_cnt.
module byte_striping_cond
  import byte_striping_cond_pkg::*;
#(
  parameter int unsigned          BUS_WIDTH = BUS_WIDTH_DEF,
  parameter logic [BUS_WIDTH-1:0] IDLE_DATA = IDLE_DATA_DEF[BUS_WIDTH-1:0]
) (
  input  logic                 clk_2f,
  input  logic                 reset,
  input  logic [BUS_WIDTH-1:0] data_in,
  input  logic                 valid_in,
  output logic [BUS_WIDTH-1:0] lane_0,
  output logic [BUS_WIDTH-1:0] lane_1,
  output logic                 valid_0,
  output logic                 valid_1
`ifdef BYTE_STRIPING_CNT_EN
  ,
  output logic [CNT_W-1:0]     byte_cnt
`endif
);

  stripe_state_e state_q, state_d;
  logic          load_0, load_1;

  // Next-state and lane-load decode; unknown encodings fall back to idle.
  always_comb begin
    state_d = state_q;
    load_0  = 1'b0;
    load_1  = 1'b0;
    case (state_q)
      ESPERANDO_ENTRADA: begin
        if (valid_in) begin
          load_0  = 1'b1;
          state_d = TRANSMITIENDO_LANE_1;
        end
      end
      TRANSMITIENDO_LANE_1: begin
        if (valid_in) begin
          load_1  = 1'b1;
          state_d = TRANSMITIENDO_LANE_0;
        end else begin
          state_d = ESPERANDO_ENTRADA;
        end
      end
      TRANSMITIENDO_LANE_0: begin
        if (valid_in) begin
          load_0  = 1'b1;
          state_d = TRANSMITIENDO_LANE_1;
        end else begin
          state_d = ESPERANDO_ENTRADA;
        end
      end
      default: begin
        state_d = ESPERANDO_ENTRADA;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      state_q <= ESPERANDO_ENTRADA;
    end else begin
      state_q <= state_d;
    end
  end

  stripe_lane_hold #(
    .BUS_WIDTH (BUS_WIDTH),
    .IDLE_DATA (IDLE_DATA)
  ) u_lane_0 (
    .clk_2f  (clk_2f),
    .reset   (reset),
    .load_i  (load_0),
    .data_i  (data_in),
    .lane_o  (lane_0),
    .valid_o (valid_0)
  );

  stripe_lane_hold #(
    .BUS_WIDTH (BUS_WIDTH),
    .IDLE_DATA (IDLE_DATA)
  ) u_lane_1 (
    .clk_2f  (clk_2f),
    .reset   (reset),
    .load_i  (load_1),
    .data_i  (data_in),
    .lane_o  (lane_1),
    .valid_o (valid_1)
  );

`ifdef BYTE_STRIPING_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Every valid byte is accepted, so count on valid_in alone.
  always_comb begin
    cnt_d = cnt_q;
    if (valid_in) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  // Byte counter register.
  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign byte_cnt = cnt_q;
`endif

endmodule
